// File: rtl/alu_cmd_seq.sv
// ============================================================================
// Module   : alu_cmd_seq
// Purpose  : Command sequencer around an external combinational 8-bit ALU:
//            accepts one command, issues it, and holds the response until it
//            is consumed. Optional accumulator chaining is enabled with the
//            macro ALU_CMD_SEQ_ACC_CHAIN_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_cmd_seq #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_opcode,
  input  logic [7:0]       cmd_a,
  input  logic [7:0]       cmd_b,
  input  logic             cmd_chain,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic [2:0]       alu_opcode,
  input  logic [7:0]       alu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_data,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [1:0] c_idle       = 2'd0;
  localparam logic [1:0] c_issue      = 2'd1;
  localparam logic [1:0] c_resp       = 2'd2;
  localparam logic [2:0] c_op_illegal = 3'b111;

  logic [1:0]       r_state;
  logic [7:0]       r_alu_a;
  logic [7:0]       r_alu_b;
  logic [2:0]       r_alu_opcode;
  logic [7:0]       r_rsp_data;
  logic             r_rsp_zero;
  logic             r_rsp_err;
  logic [CNT_W-1:0] r_op_count;

  logic             w_accept;
  logic             w_rsp_done;
  logic [7:0]       w_opnd_a;

  assign cmd_ready  = (r_state == c_idle);
  assign rsp_valid  = (r_state == c_resp);
  assign w_accept   = cmd_valid & cmd_ready;
  assign w_rsp_done = rsp_valid & rsp_ready;

  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_opcode = r_alu_opcode;
  assign rsp_data   = r_rsp_data;
  assign rsp_zero   = r_rsp_zero;
  assign rsp_err    = r_rsp_err;
  assign op_count   = r_op_count;

`ifdef ALU_CMD_SEQ_ACC_CHAIN_EN
  logic [7:0] r_acc;

  // Only successful results feed the chain; illegal-op responses leave it intact.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= 8'h00;
    end else if (w_rsp_done && !r_rsp_err) begin
      r_acc <= r_rsp_data;
    end
  end

  assign w_opnd_a = cmd_chain ? r_acc : cmd_a;
`else
  logic w_unused_chain;
  assign w_unused_chain = cmd_chain;
  assign w_opnd_a       = cmd_a;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= c_idle;
      r_alu_a      <= 8'h00;
      r_alu_b      <= 8'h00;
      r_alu_opcode <= 3'b000;
      r_rsp_data   <= 8'h00;
      r_rsp_zero   <= 1'b0;
      r_rsp_err    <= 1'b0;
      r_op_count   <= '0;
    end else begin
      case (r_state)
        c_idle: begin
          if (w_accept) begin
            // Illegal opcodes never reach the ALU, so its inputs keep their last values.
            if (cmd_opcode == c_op_illegal) begin
              r_rsp_data <= 8'h00;
              r_rsp_zero <= 1'b0;
              r_rsp_err  <= 1'b1;
              r_state    <= c_resp;
            end else begin
              r_alu_a      <= w_opnd_a;
              r_alu_b      <= cmd_b;
              r_alu_opcode <= cmd_opcode;
              r_state      <= c_issue;
            end
          end
        end
        c_issue: begin
          r_rsp_data <= alu_result;
          r_rsp_zero <= (alu_result == 8'h00);
          r_rsp_err  <= 1'b0;
          r_state    <= c_resp;
        end
        c_resp: begin
          if (w_rsp_done) begin
            r_op_count <= r_op_count + CNT_W'(1);
            r_state    <= c_idle;
          end
        end
        default: begin
          r_state <= c_idle;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/alu_cmd_seq.md
ALU_CMD_SEQ -- requirements
Module: alu_cmd_seq

Interface
REQ-001 Parameter CNT_W, default 16: width of the completed-operation counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 cmd_valid  input  1  command present.
REQ-005 cmd_ready  output  1  block accepts a command this cycle.
REQ-006 cmd_opcode  input  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 100 not-a, 101 shr1, 110 shl1, 111 illegal.
REQ-007 cmd_a, cmd_b  input  8 each  operands.
REQ-008 cmd_chain  input  1  use accumulator as operand a (effective only with ACC_CHAIN_EN).
REQ-009 alu_a, alu_b  output  8 each  operands driven to the team's combinational 8-bit ALU.
REQ-010 alu_opcode  output  3  opcode driven to the ALU.
REQ-011 alu_result  input  8  combinational ALU result, valid in the cycle after alu_* change.
REQ-012 rsp_valid  output  1  response present.
REQ-013 rsp_ready  input  1  consumer accepts response.
REQ-014 rsp_data  output  8  captured result.
REQ-015 rsp_zero  output  1  rsp_data == 0 (not set for illegal ops).
REQ-016 rsp_err  output  1  illegal opcode 111 was issued.
REQ-017 op_count  output  CNT_W  number of completed (handshaken) responses.

Function
REQ-018 FSM states IDLE, ISSUE, RESP; one operation in flight at a time.
REQ-019 cmd_ready SHALL be 1 only in IDLE; acceptance = cmd_valid & cmd_ready.
REQ-020 On acceptance, alu_a/alu_b/alu_opcode SHALL register the command fields; next state ISSUE for opcodes 000-110.
REQ-021 On acceptance of opcode 111: ALU ports not updated, rsp_data=0, rsp_err=1, rsp_zero=0, next state RESP directly.
REQ-022 ISSUE lasts exactly one cycle: at its end rsp_data<=alu_result, rsp_zero<=(alu_result==0), rsp_err<=0, next RESP.
REQ-023 Latency: command accepted at edge N -> rsp_valid high after edge N+2 (N+1 for illegal).
REQ-024 RESP: rsp_valid=1; rsp_data/rsp_zero/rsp_err stable until rsp_valid & rsp_ready; then IDLE and op_count increments.
REQ-025 rsp_valid SHALL NOT drop without rsp_ready (no retraction under backpressure).
REQ-026 A new command cannot be accepted in the same cycle a response completes; next acceptance earliest one cycle later (IDLE).
REQ-027 alu_a/alu_b/alu_opcode hold their last values in IDLE and RESP (no toggling).
REQ-028 op_count wraps modulo 2^CNT_W (all-ones + 1 -> 0).
REQ-029 Results are 8-bit modulo: carry/borrow discarded (e.g. 0xFF+0x01 -> 0x00, rsp_zero=1).

Reset
REQ-030 rst high at a clock edge SHALL force state IDLE and all outputs/registers to 0 (cmd_ready=1 after reset, rsp_valid=0, alu_* =0, op_count=0, accumulator=0).
REQ-031 Reset mid-operation (ISSUE or RESP) SHALL abandon the operation; no response emitted, op_count not incremented.
REQ-032 rst dominates cmd_valid and rsp_ready in the same cycle.

Configuration
REQ-033 Macro ALU_CMD_SEQ_ACC_CHAIN_EN: when defined, an 8-bit accumulator SHALL load rsp_data on each non-error response handshake, and an accepted command with cmd_chain=1 SHALL drive alu_a from the accumulator instead of cmd_a.
REQ-034 Without ALU_CMD_SEQ_ACC_CHAIN_EN: no accumulator; cmd_chain port present but ignored; alu_a always from cmd_a.

Verification
REQ-035 Reset, then add 0x12+0x34, rsp_ready=1 -> rsp_valid 2 cycles after accept, rsp_data=0x46, rsp_zero=0, op_count=1.
REQ-036 sub 0x05-0x05 with rsp_ready held low 5 cycles -> rsp_valid high and rsp_data=0x00, rsp_zero=1 stable all 5 cycles; cmd_ready=0 throughout.
REQ-037 Opcode 111 -> rsp_valid 1 cycle after accept, rsp_err=1, rsp_data=0x00, alu_* unchanged.
REQ-038 Assert rst while in RESP -> next cycle rsp_valid=0, cmd_ready=1, op_count unchanged from before the op (reset to 0).
REQ-039 ACC_CHAIN_EN: add 0x10+0x20, then chained add b=0x01 -> second rsp_data=0x31; without macro same sequence with cmd_a=0x00 -> 0x01.
REQ-040 CNT_W=4, 16 back-to-back ops -> op_count returns to 0; shl1 of 0x81 -> 0x02.
